// File: rtl/imem_sram_pkg.sv
// Shared types and constants for the instruction-memory SRAM controller.
// The optional power-up clear sweep is enabled with IMEM_CLEAR_ON_RESET_EN.
package imem_sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH      = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Counter wide enough to hold 0..max_outstanding inclusive.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// In-order read-response FIFO with registered empty/full flags.
// A push and a pop on the same edge are legal even when full.
module imem_rsp_fifo
  import imem_sram_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  DEPTH      = DEF_MAX_OUTSTANDING,
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, full_q;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);
  assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/imem_sram_ctrl.sv
// Initiator-side controller for the single-port OpenRAM instruction memory.
// Define IMEM_CLEAR_ON_RESET_EN to zero the whole macro after reset release.
module imem_sram_ctrl
  import imem_sram_pkg::*;
#(
  parameter int  DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int  MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output state_t                dbg_state,
  output logic [CNT_W-1:0]      dbg_cnt,
  output logic                  dbg_fifo_full
);

  // Handshakes: a request transfers on a clk0 edge where req_valid & req_ready;
  // a response transfers on an edge where rsp_valid & rsp_ready. Once raised,
  // rsp_valid and rsp_data hold until that transfer.

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

`ifdef IMEM_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = INIT;
  logic [ADDR_WIDTH-1:0] init_addr_q;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            tag_q;
  logic                  req_ready_q;
  logic                  csb0_q, web0_q;
  logic [ADDR_WIDTH-1:0] addr0_q;
  logic [DATA_WIDTH-1:0] din0_q;
  logic                  accept, read_accept, pop;
  logic                  fifo_empty, fifo_full;

  assign accept      = req_valid & req_ready_q;
  assign read_accept = accept & ~req_we;
  assign pop         = rsp_valid & rsp_ready;
  assign cnt_d       = cnt_q + CNT_W'(read_accept) - CNT_W'(pop);

  // tag_q[0]: read registered on the pins; tag_q[1]: macro has sampled it,
  // so dout0 is valid at the next edge and gets pushed.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      tag_q       <= '0;
      req_ready_q <= 1'b0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
`ifdef IMEM_CLEAR_ON_RESET_EN
      init_addr_q <= '0;
`endif
    end else begin
      tag_q <= {tag_q[0], read_accept};
      cnt_q <= cnt_d;
      case (state_q)
        INIT: begin
`ifdef IMEM_CLEAR_ON_RESET_EN
          csb0_q      <= 1'b0;
          web0_q      <= 1'b0;
          din0_q      <= '0;
          addr0_q     <= init_addr_q;
          init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
          if (init_addr_q == '1) begin
            state_q     <= RUN;
            req_ready_q <= 1'b1;
          end else begin
            req_ready_q <= 1'b0;
          end
`else
          state_q <= RUN;
`endif
        end
        RUN: begin
          req_ready_q <= (cnt_d < CNT_MAX);
          if (accept) begin
            csb0_q  <= 1'b0;
            web0_q  <= ~req_we;
            addr0_q <= req_addr;
            din0_q  <= req_wdata;
          end else begin
            csb0_q <= 1'b1;
            web0_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  imem_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i   (clk0),
    .rst_ni  (rst_n),
    .push_i  (tag_q[1]),
    .wdata_i (dout0),
    .pop_i   (pop),
    .rdata_o (rsp_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign req_ready     = req_ready_q;
  assign rsp_valid     = ~fifo_empty;
  assign busy          = (state_q == INIT) || (cnt_q != '0);
  assign csb0          = csb0_q;
  assign web0          = web0_q;
  assign addr0         = addr0_q;
  assign din0          = din0_q;
  assign dbg_state     = state_q;
  assign dbg_cnt       = cnt_q;
  assign dbg_fifo_full = fifo_full;

endmodule

// File: doc/imem_sram_ctrl.md
# imem_sram_ctrl

Initiator-side controller for the single-port OpenRAM instruction-memory macro (`sram_2_16_sky130A` port 0 protocol). Accepts word read/write requests from the core fetch/program path over a valid/ready channel. Drives the macro's `csb0/web0/addr0/din0` pins and captures `dout0` into an in-order response FIFO with backpressure. Sits between the RISC-V fetch unit and the external SRAM macro.

## Interface
- `DATA_WIDTH`, 32, SRAM word width
- `ADDR_WIDTH`, 4, word address width; depth = 2^ADDR_WIDTH
- `MAX_OUTSTANDING`, 4, read credits and response FIFO depth; minimum 1

- `clk0` in 1: single clock, shared with the SRAM macro
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted on edge where `req_valid & req_ready`
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_WIDTH: word address
- `req_wdata` in DATA_WIDTH: write data
- `rsp_valid` out 1: read data available
- `rsp_ready` in 1: consumer takes response
- `rsp_data` out DATA_WIDTH: read data, request order
- `busy` out 1: init sweep running or reads outstanding
- `csb0` out 1: SRAM chip select, active-low
- `web0` out 1: SRAM write enable, active-low
- `addr0` out ADDR_WIDTH: SRAM address
- `din0` out DATA_WIDTH: SRAM write data
- `dout0` in DATA_WIDTH: SRAM read data

## Operation
- FSM states: `INIT` (clear sweep, macro only), `RUN`. Reset enters `INIT` if compiled in, else `RUN`.
- `cnt` = reads accepted and not yet popped. `req_ready = (state==RUN) && (cnt < MAX_OUTSTANDING)`, from registered state only. Writes need `req_ready` but do not consume credit.
- Accept: at edge E0, register `csb0=0`, `web0=~req_we`, `addr0=req_addr`, `din0=req_wdata`. No accept at an edge: `csb0=1`, `web0=1`, `addr0`/`din0` hold.
- Read pipeline: E0 accept; E1 macro samples pins; macro updates `dout0` on the following negedge; E2 controller pushes `dout0` into the FIFO. Track with a 2-stage read-tag shift register.
- FIFO pop on `rsp_valid & rsp_ready`. `cnt` next = `cnt + read_accept - pop`. Simultaneous push and pop on a full FIFO is legal. Credits guarantee no overflow.
- `rsp_data` holds stable while `rsp_valid & ~rsp_ready`.
- Writes produce no response. Read-after-write to the same address, accepted on consecutive edges, returns the new data.
- Reset mid-operation: reset clears FIFO, `cnt` and tag pipe. A read already captured by the macro completes at the macro but is discarded. No `rsp_valid` for pre-reset requests.

## Timing
- Reset values: `csb0=1`, `web0=1`, `addr0=0`, `din0=0`, `rsp_valid=0`, `rsp_data=0`, `req_ready=0`, `busy` = 1 if `INIT` else 0.
- Read latency: `rsp_valid` first high in the cycle after E2, i.e. 2 cycles after accept.
- With `rsp_ready=1` and MAX_OUTSTANDING ≥ 4: one read accepted and returned per cycle sustained. `cnt` steady at 3.
- With `rsp_ready=0`: exactly MAX_OUTSTANDING reads accepted, then `req_ready` low until a pop. `req_ready` rises the cycle after the popping edge.

## Configuration
- `IMEM_CLEAR_ON_RESET_EN` defined: after `rst_n` release, `INIT` writes 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle (`csb0=0`, `web0=0`, `din0=0`). `req_ready=0` and `busy=1` throughout. `INIT` moves to `RUN` after the last write is registered.
- Not defined: no `INIT` state; `RUN` immediately after reset.

## Structure
- Package `imem_sram_pkg`: state enum (`INIT`, `RUN`), default width constants, credit-counter width function (`$clog2(MAX_OUTSTANDING+1)`).
- Sub-module `imem_rsp_fifo`: synchronous FIFO, depth MAX_OUTSTANDING, registered `empty`/`full`, async active-low reset. The controller holds the FSM, credit counter, read-tag pipe and pin registers.

## Test plan
- Reset: hold `rst_n=0` → `csb0=1`, `web0=1`, `addr0=0`, `din0=0`, `rsp_valid=0`, `req_ready=0`. Release (macro off) → `req_ready=1` next cycle.
- Write 0xDEADBEEF @3, then read @3 on the next edge → `rsp_valid` 2 cycles after read accept, `rsp_data=0xDEADBEEF`.
- Preload addr n = n×0x11111111, n = 0..7. Back-to-back reads 0..7 with `rsp_ready=1` → 8 responses on consecutive cycles, in order; `req_ready` never drops.
- `rsp_ready=0`, offer 6 reads → exactly 4 accepted, `req_ready=0`. Raise `rsp_ready` → 4 in-order responses, remaining 2 then accepted.
- Two reads accepted, `rst_n` pulsed low before E2 → after release no `rsp_valid`, `cnt=0`, `busy=0`.
- `IMEM_CLEAR_ON_RESET_EN`, ADDR_WIDTH=4 → 16 zero writes to addresses 0..15 on consecutive cycles, `busy=1`. `req_ready` rises after the sweep; reading @9 returns 0.
